// File: rtl/wavelet_pkg.sv
// wavelet_pkg: shared widths and FSM state encoding for the wavelet scan controller.
package wavelet_pkg;
  localparam int SAMPLE_W = 8;
  localparam int SEL_W = 8;
  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, PRESENT} state_e;
endpackage

// File: rtl/wavelet_sync_edge.sv
// wavelet_sync_edge: two-flop synchronizer for the pad strobe plus rising-edge detect.
module wavelet_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);
  logic [2:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[1:0], i_async};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
  assign o_rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/wavelet_scan_ctrl.sv
// wavelet_scan_ctrl: latches a pad sample, pulses the datapath clock, then scans every channel into a ready/valid frame stream.
module wavelet_scan_ctrl
  import wavelet_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int PULSE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_data_clk,
  input  logic [SAMPLE_W-1:0] i_value,
  output logic                o_dt_data_clk,
  output logic [SAMPLE_W-1:0] o_dt_value,
  output logic [SEL_W-1:0]    o_select_output_channel,
  input  logic [SAMPLE_W-1:0] i_wavelet_out,
  input  logic                i_active,
  output logic [SAMPLE_W-1:0] o_frame_data,
  output logic                o_frame_valid,
  input  logic                i_frame_ready,
  output logic                o_frame_last,
  output logic                o_busy,
  output logic                o_overrun
);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CHANNELS - 1);
  localparam logic [3:0] PULSE_END = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] SETTLE_END = 4'(SETTLE_CYCLES - 1);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d, sel_q, sel_d;
  logic [SAMPLE_W-1:0] value_q, value_d, data_q, data_d;
  logic dclk_q, dclk_d, valid_q, valid_d, last_q, last_d, overrun_q, overrun_d;
  logic rise;
  wavelet_sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(i_data_clk),
    .o_rise (rise)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    sel_d = sel_q;
    value_d = value_q;
    dclk_d = dclk_q;
    data_d = data_q;
    valid_d = valid_q;
    last_d = last_q;
    // edges outside IDLE, including the cycle we return to IDLE, are dropped
    overrun_d = overrun_q | (rise && state_q != IDLE);
    case (state_q)
      IDLE: if (rise) begin
        value_d = i_value;
        dclk_d = 1'b1;
        cnt_d = '0;
        state_d = PULSE;
      end
      PULSE: if (cnt_q == PULSE_END) begin
        dclk_d = 1'b0;
        cnt_d = '0;
        idx_d = i_active ? '0 : idx_q;
        sel_d = i_active ? '0 : sel_q;
        state_d = i_active ? SETTLE : IDLE;
      end else cnt_d = cnt_q + 4'd1;
      SETTLE: if (cnt_q == SETTLE_END) begin
        data_d = i_wavelet_out;
        valid_d = 1'b1;
        last_d = idx_q == LAST_IDX;
        state_d = PRESENT;
      end else cnt_d = cnt_q + 4'd1;
      PRESENT: if (i_frame_ready) begin
        valid_d = 1'b0;
        last_d = 1'b0;
        cnt_d = '0;
        idx_d = last_q ? idx_q : idx_q + 8'd1;
        sel_d = last_q ? sel_q : idx_q + 8'd1;
        state_d = last_q ? IDLE : SETTLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sel_q <= '0;
      value_q <= '0;
      dclk_q <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sel_q <= sel_d;
      value_q <= value_d;
      dclk_q <= dclk_d;
      data_q <= data_d;
      valid_q <= valid_d;
      last_q <= last_d;
      overrun_q <= overrun_d;
    end
  assign o_dt_data_clk = dclk_q;
  assign o_dt_value = value_q;
  assign o_select_output_channel = sel_q;
  assign o_frame_data = data_q;
  assign o_frame_valid = valid_q;
  assign o_frame_last = last_q;
  assign o_busy = state_q != IDLE;
  assign o_overrun = overrun_q;
endmodule

// File: doc/wavelet_scan_ctrl.md
WAVELET_SCAN_CTRL -- requirements
Module: wavelet_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 8: number of output channels scanned per sample, range 1..256.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2: wait cycles after a select change before capture, range 1..15.
REQ-003 SHALL have parameter PULSE_CYCLES, default 2: high time of the forwarded data clock, range 1..15.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port i_data_clk, input, 1: external sample strobe from pad, asynchronous to clk.
REQ-007 SHALL have port i_value, input, 8: external sample, stable while i_data_clk is high.
REQ-008 SHALL have port o_dt_data_clk, output, 1: data clock to the transform datapath.
REQ-009 SHALL have port o_dt_value, output, 8: latched sample to the datapath.
REQ-010 SHALL have port o_select_output_channel, output, 8: channel select to the datapath.
REQ-011 SHALL have port i_wavelet_out, input, 8: multiplexed datapath output.
REQ-012 SHALL have port i_active, input, 1: datapath active flag.
REQ-013 SHALL have ports o_frame_data (output, 8), o_frame_valid (output, 1), i_frame_ready (input, 1) and o_frame_last (output, 1): captured-result stream.
REQ-014 SHALL have ports o_busy (output, 1), scan in progress, and o_overrun (output, 1), sticky dropped-sample flag.

Function
REQ-015 SHALL pass i_data_clk through a 2-flop synchronizer; a rising edge is detected in cycle E, the first cycle the second flop is high and was low in the previous cycle.
REQ-016 SHALL use FSM states IDLE, PULSE, SETTLE, PRESENT.
REQ-017 IDLE: on edge E, SHALL latch i_value into o_dt_value at the end of cycle E and enter PULSE.
REQ-018 PULSE: SHALL hold o_dt_data_clk high for exactly PULSE_CYCLES cycles, starting cycle E+1, then go low.
REQ-019 After PULSE, if i_active=1 the FSM SHALL set channel index 0 and enter SETTLE; if i_active=0 it SHALL return to IDLE with no frame produced.
REQ-020 SETTLE: SHALL drive o_select_output_channel = current index, wait SETTLE_CYCLES cycles, capture i_wavelet_out into o_frame_data, then enter PRESENT.
REQ-021 PRESENT: SHALL hold o_frame_valid=1 with o_frame_data stable until a cycle with i_frame_ready=1; transfer occurs in that cycle.
REQ-022 o_frame_last SHALL be 1 in PRESENT exactly when index = NUM_CHANNELS-1.
REQ-023 On transfer with index < NUM_CHANNELS-1, SHALL increment the index and enter SETTLE; on transfer of the last channel, SHALL enter IDLE.
REQ-024 i_frame_ready SHALL be ignored outside PRESENT; o_frame_valid SHALL never drop without a transfer, except on reset.
REQ-025 o_busy SHALL be 1 in every state except IDLE.
REQ-026 An edge detected while not in IDLE SHALL be dropped, with no latch and no pulse, and SHALL set o_overrun; an edge in the same cycle the FSM returns to IDLE also counts as dropped.
REQ-027 The channel index SHALL be 8 bits, and increments SHALL never pass NUM_CHANNELS-1.
REQ-028 o_select_output_channel SHALL hold its last value in IDLE and PULSE.

Reset
REQ-029 rst_n=0 SHALL asynchronously force: state IDLE, synchronizer flops 0, o_dt_data_clk 0, o_dt_value 0, o_select_output_channel 0, o_frame_data 0, o_frame_valid 0, o_frame_last 0, o_busy 0, o_overrun 0, index 0.
REQ-030 Reset asserted mid-scan SHALL abandon the frame; after release the block SHALL wait for a fresh edge.
REQ-031 o_overrun SHALL clear only on reset.

Structure
REQ-032 A shared package wavelet_pkg SHALL hold the FSM state enum, the sample width (8) and the channel select width (8).
REQ-033 The synchronizer plus edge detector SHALL be the sub-module wavelet_sync_edge; all other logic SHALL be flat.

Verification
REQ-034 Defaults, i_active=1, ready tied 1, one i_data_clk pulse with i_value=0x5A -> o_dt_value=0x5A; o_dt_data_clk high 2 cycles from E+1; 8 frames on selects 0..7, each frame equal to the model output for that channel; last asserted on channel 7 only; o_busy then 0.
REQ-035 Ready low for 5 cycles on channel 3 -> o_frame_valid held, data and select stable, no index advance.
REQ-036 Second i_data_clk edge during the scan -> no extra pulse; o_overrun=1 and stays 1; scan completes normally.
REQ-037 i_active=0 at the end of PULSE -> no frames; IDLE reached 1 cycle after the pulse ends.
REQ-038 rst_n low during channel 4 SETTLE -> all outputs 0 immediately (asynchronous); after release, a new edge starts the scan at channel 0.
REQ-039 NUM_CHANNELS=1, SETTLE_CYCLES=1 -> a single frame with o_frame_last=1, then IDLE.
